jtcop_obj_dma: RTL
==================

# jtcop_obj_dma

Object-table DMA and double buffer feeding the sprite draw stage. On a CPU trigger it copies the 1024-word CPU object RAM into the back bank of an internal two-bank table. At the next vertical blank it makes that copy visible to the draw engine, so sprites never tear mid-frame. The draw engine reads the front bank through `tbl_addr`/`tbl_dout`.

## Interface
Parameters:
- `AUTO`, 0, when 1 a copy is also triggered on every LVBL falling edge, as if `dma_trig` pulsed.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `LVBL` in 1: vertical blank, active-low.
- `dma_trig` in 1: one-cycle pulse from the CPU register write that requests a copy.
- `ram_cs` out 1: read request to the CPU object RAM.
- `ram_addr` out 10: word address of the read request.
- `ram_dout` in 16: read data from the CPU object RAM.
- `ram_ok` in 1: read data valid.
- `tbl_addr` in 10: draw-engine read address into the front bank.
- `tbl_dout` out 16: front-bank data, registered.
- `busy` out 1: copy in progress.
- `bank` out 1: index of the current front bank.

## Operation
- The table is 2×1024×16.
- The front bank is `bank`. The back bank is `~bank`.
- Draw reads always hit the front bank. DMA writes always hit the back bank.
- States:
  - IDLE: `ram_cs`=0. A pending trigger moves to REQ with `ram_addr`=0.
  - REQ: `ram_cs`=1 and `ram_addr` are held stable. `ram_ok` is ignored in the first cycle after entering REQ (guard cycle). Thereafter, `ram_ok`=1 captures `ram_dout` and moves to WR.
  - WR: writes the captured word to `back[ram_addr]`.
    - If `ram_addr`==1023: go to IDLE, set `dirty`.
    - Otherwise: `ram_addr`+1, go to REQ.
- `busy` = state≠IDLE.
- `pend` flag: set by `dma_trig` (or by the LVBL falling edge when `AUTO`=1).
  - Cleared when IDLE accepts it.
  - A trigger arriving while busy restarts the copy from address 0 on the next WR→REQ boundary and clears `dirty`.
  - Multiple triggers in one copy collapse into one restart.
- Swap: on the LVBL falling edge (LVBL=0 and last-cycle LVBL=1):
  - If state is IDLE and `dirty`=1: `bank` toggles and `dirty` clears.
  - If a copy is in progress: no swap. The swap is deferred to a later vblank edge after the copy completes.
- A trigger and a swap-eligible vblank edge in the same cycle: the swap happens first, then the copy starts into the new back bank.
- `ram_addr` arithmetic is 10-bit. Wrap past 1023 never occurs, because completion is detected at 1023.

## Timing
- Reset values:
  - `ram_cs`=0, `ram_addr`=0, `busy`=0, `bank`=0, `tbl_dout`=0.
  - `pend`=0, `dirty`=0, state IDLE.
  - Table contents are undefined after reset.
- The `rst_n` assertion mid-copy aborts immediately: all of the above reset values apply and no swap follows.
- `tbl_dout` latency: 1 clock after `tbl_addr`. It reflects the bank selected at the time of the read.
- The copy start is registered: `ram_cs` rises the cycle after IDLE sees `pend`, i.e. 2 clocks after a `dma_trig` pulse.
- Minimum per word: 1 guard cycle + 1 capture cycle + 1 WR cycle = 3 clocks. A full copy takes ≥3072 clocks when `ram_ok` is held high.
- `ram_ok` may stay high continuously. The guard cycle prevents stale data from being taken as valid.
- The `bank` change is visible on `tbl_dout` one clock after the swap edge.

## Structure
- No shared-package content is needed. Local constants: state encoding and the last address 10'd1023.
- One sub-module: `jtcop_obj_tblram`, a 2048×16 dual-port RAM.
  - Write port: DMA, address {~bank, ram_addr}.
  - Read port: draw engine, address {bank, tbl_addr}, registered output.
- Edge detect on LVBL uses one register.

## Test plan
- Reset, then one `dma_trig` with RAM[i]=i^16'hA5A5 and `ram_ok` tied high:
  - `busy` high for 3072 clocks.
  - After the next LVBL falling edge, `bank`=1 and `tbl_dout` for `tbl_addr`=5 is 16'hA5A0.
- `ram_ok` held low for 10 cycles per word:
  - Data is still captured only at the first qualified `ram_ok`.
  - No word is duplicated or skipped; the table is checked against RAM.
- LVBL falling edge at word 500 of a copy:
  - `bank` is unchanged and reads still return the old front bank.
  - The swap occurs at the following vblank edge.
- Second `dma_trig` at word 300:
  - The copy restarts at address 0.
  - The final table equals the RAM contents at restart time.
  - Total busy time is ≈3072+900 clocks.
- `dma_trig` in the same cycle as a swap-eligible vblank edge:
  - `bank` toggles.
  - The new copy writes the new back bank.
  - Front-bank reads stay constant throughout the copy.
- `rst_n` pulsed low at word 700:
  - `ram_cs`, `busy` and `bank` all go to 0 asynchronously.
  - No swap occurs at the next vblank.
- `AUTO`=1:
  - Each vblank edge starts a copy.
  - That copy's result is displayed after the subsequent vblank edge.

Source files
------------

// File: rtl/jtcop_obj_dma_pkg.sv
`default_nettype none
// ============================================================================
// jtcop_obj_dma_pkg : state encoding and constants for the object-table DMA
// Rev 1.0
// ============================================================================
package jtcop_obj_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WR   = 2'd2
  } dma_state_t;

  localparam logic [9:0] c_last_addr = 10'd1023;

endpackage
`default_nettype wire

// File: rtl/jtcop_obj_tblram.sv
`default_nettype none
// ============================================================================
// jtcop_obj_tblram : 2048x16 dual-port table RAM, registered read port
// Rev 1.0
// ============================================================================
module jtcop_obj_tblram (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [10:0] waddr,
  input  logic [15:0] wdata,
  input  logic [10:0] raddr,
  output logic [15:0] dout
);

  logic [15:0] r_mem [0:2047];
  logic [15:0] r_dout;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array itself holds no reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dout <= 16'd0;
    else        r_dout <= r_mem[raddr];
  end

  assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/jtcop_obj_dma.sv
`default_nettype none
// ============================================================================
// jtcop_obj_dma : copies CPU object RAM into the back bank of a double-buffered
//                 sprite table and flips banks at vertical blank
// Rev 1.0
// ============================================================================
module jtcop_obj_dma
  import jtcop_obj_dma_pkg::*;
#(
  parameter bit AUTO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LVBL,
  input  logic        dma_trig,
  output logic        ram_cs,
  output logic [9:0]  ram_addr,
  input  logic [15:0] ram_dout,
  input  logic        ram_ok,
  input  logic [9:0]  tbl_addr,
  output logic [15:0] tbl_dout,
  output logic        busy,
  output logic        bank
);

  dma_state_t  r_state;
  logic        r_guard;
  logic        r_pend;
  logic        r_dirty;
  logic        r_lvbl_l;
  logic        r_bank;
  logic        r_cs;
  logic        r_busy;
  logic [9:0]  r_addr;
  logic [15:0] r_data;

  logic        w_vb_fall;
  logic        w_trig;
  logic        w_swap;
  logic        w_we;

  assign w_vb_fall = r_lvbl_l & ~LVBL;
  assign w_trig    = dma_trig | (AUTO & w_vb_fall);
  assign w_swap    = (r_state == ST_IDLE) & r_dirty & w_vb_fall;
  assign w_we      = (r_state == ST_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_guard  <= 1'b0;
      r_pend   <= 1'b0;
      r_dirty  <= 1'b0;
      r_lvbl_l <= 1'b0;
      r_bank   <= 1'b0;
      r_cs     <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= 10'd0;
      r_data   <= 16'd0;
    end else begin
      r_lvbl_l <= LVBL;
      if (w_trig) r_pend <= 1'b1;
      // Swap only while idle, so a bank flip never lands mid-copy.
      if (w_swap) begin
        r_bank  <= ~r_bank;
        r_dirty <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            r_state <= ST_REQ;
            r_addr  <= 10'd0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b1;
            r_guard <= 1'b1;
            r_pend  <= w_trig;
          end
        end
        ST_REQ: begin
          // First REQ cycle ignores ram_ok: data may still be for the old address.
          r_guard <= 1'b0;
          if (!r_guard && ram_ok) begin
            r_data  <= ram_dout;
            r_cs    <= 1'b0;
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (r_pend) begin
            r_addr  <= 10'd0;
            r_cs    <= 1'b1;
            r_guard <= 1'b1;
            r_pend  <= w_trig;
            r_dirty <= 1'b0;
            r_state <= ST_REQ;
          end else if (r_addr == c_last_addr) begin
            r_busy  <= 1'b0;
            r_dirty <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_addr  <= r_addr + 10'd1;
            r_cs    <= 1'b1;
            r_guard <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  jtcop_obj_tblram u_tblram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr ({~r_bank, r_addr}),
    .wdata (r_data),
    .raddr ({r_bank, tbl_addr}),
    .dout  (tbl_dout)
  );

  assign ram_cs   = r_cs;
  assign ram_addr = r_addr;
  assign busy     = r_busy;
  assign bank     = r_bank;

endmodule
`default_nettype wire
